// File: rtl/buzzer_seq_arbiter.sv
// buzzer_seq_arbiter
//   Round-robin arbiter and player for Morse beep patterns. Two requesters
//   offer a pattern vector and a valid bit count. The granted pattern is
//   played one bit per UNIT_CYC cycles, most significant valid bit first,
//   as a square-wave tone. A fixed silent gap of GAP_UNITS units follows,
//   and a done pulse is raised on the last gap cycle.
//
//   Build option: define BUZZER_SEQ_LEVEL_EN to drive the buzzer with a
//   steady level equal to the current bit (active buzzer). The tone
//   generator is then left out. Timing, handshake and done do not change.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   req0/pat0/wid0      requester 0 (decoded-character echo)
//   req1/pat1/wid1      requester 1 (transmit keyer)
//   abort               stop playback at the next edge
//   ack0, ack1          one-cycle grant pulse, pattern captured
//   busy                high outside IDLE
//   cur_src             source of the pattern in progress
//   done                one-cycle pulse on the last gap cycle
//   buzzer              registered buzzer drive
module buzzer_seq_arbiter #(
  parameter int PAT_W     = 75,
  parameter int WID_W     = 7,
  parameter int UNIT_CYC  = 5000000,
  parameter int TONE_HALF = 50000,
  parameter int GAP_UNITS = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic [PAT_W-1:0] pat0,
  input  logic [WID_W-1:0] wid0,
  input  logic             req1,
  input  logic [PAT_W-1:0] pat1,
  input  logic [WID_W-1:0] wid1,
  input  logic             abort,
  output logic             ack0,
  output logic             ack1,
  output logic             busy,
  output logic             cur_src,
  output logic             done,
  output logic             buzzer
);

  localparam int GAP_CYC = GAP_UNITS * UNIT_CYC;
  // One counter times both a bit and the whole gap; the gap is the longer.
  localparam int CNT_W = $clog2(GAP_CYC);
  localparam logic [CNT_W-1:0] UNIT_LAST = CNT_W'(UNIT_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_PRE   = CNT_W'(GAP_CYC - 2);

  typedef enum logic [1:0] {S_IDLE, S_PLAY, S_GAP} state_t;

  state_t             r_state;
  logic [WID_W-1:0]   r_rem;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_last_src;
  logic               r_cur_src;
  logic               r_ack0;
  logic               r_ack1;
  logic               r_busy;
  logic               r_done;
  logic               r_buzzer;
  logic [PAT_W-1:0]   r_sh;

  logic               w_gnt_src;
  logic               w_grant;
  logic [WID_W-1:0]   w_wid_raw;
  logic [WID_W-1:0]   w_wid;
  logic [PAT_W-1:0]   w_pat_al;
  logic               w_bit_end;
  logic               w_bit_start;
  logic               w_start_bit;
  logic               w_in_bit;

  // On a tie the requester that did not win last time is granted.
  assign w_gnt_src = (req0 & req1) ? ~r_last_src : req1;
  assign w_grant   = (r_state == S_IDLE) & (req0 | req1) & ~abort;
  assign w_wid_raw = w_gnt_src ? wid1 : wid0;
  assign w_wid     = (w_wid_raw > WID_W'(PAT_W)) ? WID_W'(PAT_W) : w_wid_raw;
  // Left-align the valid bits so the bit being played is always the MSB.
  assign w_pat_al  = (w_gnt_src ? pat1 : pat0) << (WID_W'(PAT_W) - w_wid);

  assign w_bit_end   = (r_state == S_PLAY) & (r_cnt == UNIT_LAST);
  assign w_bit_start = (w_grant & (w_wid != '0)) |
                       (w_bit_end & (r_rem != WID_W'(1)) & ~abort);
  assign w_start_bit = w_grant ? w_pat_al[PAT_W-1] : r_sh[PAT_W-2];
  assign w_in_bit    = (r_state == S_PLAY) & ~w_bit_end & ~abort;

  assign ack0    = r_ack0;
  assign ack1    = r_ack1;
  assign busy    = r_busy;
  assign cur_src = r_cur_src;
  assign done    = r_done;
  assign buzzer  = r_buzzer;

  // Pattern shift register: datapath only, loaded on every grant.
  always_ff @(posedge clk) begin
    if (w_grant) begin
      r_sh <= w_pat_al;
    end else if (w_bit_end) begin
      r_sh <= {r_sh[PAT_W-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_rem      <= '0;
      r_cnt      <= '0;
      r_last_src <= 1'b1;
      r_cur_src  <= 1'b0;
      r_ack0     <= 1'b0;
      r_ack1     <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_ack0 <= 1'b0;
      r_ack1 <= 1'b0;
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_grant) begin
            r_cur_src  <= w_gnt_src;
            r_last_src <= w_gnt_src;
            r_ack0     <= ~w_gnt_src;
            r_ack1     <= w_gnt_src;
            r_rem      <= w_wid;
            r_cnt      <= '0;
            r_busy     <= 1'b1;
            r_state    <= (w_wid == '0) ? S_GAP : S_PLAY;
          end
        end
        S_PLAY: begin
          if (abort) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_cnt   <= '0;
          end else if (w_bit_end) begin
            r_cnt <= '0;
            r_rem <= r_rem - WID_W'(1);
            if (r_rem == WID_W'(1)) begin
              r_state <= S_GAP;
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_GAP: begin
          if (abort) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_cnt   <= '0;
          end else if (r_cnt == GAP_LAST) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_cnt   <= '0;
          end else begin
            r_cnt  <= r_cnt + CNT_W'(1);
            // Registered, so raised one cycle early to land on the last gap cycle.
            r_done <= (r_cnt == GAP_PRE);
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef BUZZER_SEQ_LEVEL_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_buzzer <= 1'b0;
    end else if (w_bit_start) begin
      r_buzzer <= w_start_bit;
    end else if (!w_in_bit) begin
      r_buzzer <= 1'b0;
    end
  end
`else
  localparam int TC_W = (TONE_HALF > 1) ? $clog2(TONE_HALF) : 1;
  localparam logic [TC_W-1:0] TH_LAST = TC_W'(TONE_HALF - 1);

  logic            r_phase;
  logic [TC_W-1:0] r_tcnt;

  // Every bit starts in the high tone phase; the phase flips each TONE_HALF.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_phase  <= 1'b0;
      r_tcnt   <= '0;
      r_buzzer <= 1'b0;
    end else if (w_bit_start) begin
      r_phase  <= 1'b1;
      r_tcnt   <= '0;
      r_buzzer <= w_start_bit;
    end else if (w_in_bit) begin
      if (r_tcnt == TH_LAST) begin
        r_tcnt   <= '0;
        r_phase  <= ~r_phase;
        r_buzzer <= r_sh[PAT_W-1] & ~r_phase;
      end else begin
        r_tcnt <= r_tcnt + TC_W'(1);
      end
    end else begin
      r_buzzer <= 1'b0;
    end
  end
`endif

endmodule
